// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_W  = 4;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    typedef enum logic {
        S_IDLE,
        S_HELD
    } state_e;

    // Per-scan result: bit 4 = exactly one key seen, bits 3:0 = its code.
    typedef logic [KEY_W:0] result_t;
    localparam result_t NO_KEY = '0;

    function automatic logic [2:0] low_count(input logic [N_ROWS-1:0] lows);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            n = n + {2'b00, lows[i]};
        end
        return n;
    endfunction

    function automatic logic [1:0] low_index(input logic [N_ROWS-1:0] lows);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (lows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key outputs.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Generic two-flop synchronizer; idles high to match pulled-up inputs.
module keypad_row_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-multiplexed 4x4 keypad reader with whole-scan debounce and
// single-key acceptance (ghosted / multi-key scans read as no key).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 2500,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(DEBOUNCE_SCANS - 1);

    logic [N_ROWS-1:0] row_s;

    keypad_row_sync #(.W(N_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (kp.row),
        .q_o (row_s)
    );

    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         col_idx_q;
    logic [1:0]         lows_q;      // low bits seen so far this scan, saturating at 2
    logic [KEY_W-1:0]   acc_code_q;
    result_t            prev_res_q;
    logic [MATCH_W-1:0] match_q;

    state_e             state_q;
    logic [KEY_W-1:0]   key_code_q;
    logic               key_valid_q;
    logic               key_down_q;

    logic               sample_d;
    logic               scan_end_d;
    logic [N_ROWS-1:0]  lows_now_d;
    logic [2:0]         n_now_d;
    logic [2:0]         tot_d;
    logic [1:0]         lows_d;
    logic [KEY_W-1:0]   acc_code_d;
    result_t            res_d;
    logic [MATCH_W-1:0] match_d;
    logic               stable_d;

    // Results include the column being sampled this cycle so the scan-end
    // decision sees all four columns without an extra pipeline stage.
    always_comb begin
        sample_d   = (dwell_q == DWELL_LAST);
        scan_end_d = sample_d && (col_idx_q == 2'd3);
        lows_now_d = ~row_s;
        n_now_d    = low_count(lows_now_d);
        tot_d      = {1'b0, lows_q} + n_now_d;
        lows_d     = (tot_d > 3'd2) ? 2'd2 : tot_d[1:0];
        acc_code_d = acc_code_q;
        if (lows_q == 2'd0 && n_now_d == 3'd1) begin
            acc_code_d = {low_index(lows_now_d), col_idx_q};
        end
        res_d   = (lows_d == 2'd1) ? {1'b1, acc_code_d} : NO_KEY;
        match_d = match_q;
        if (res_d != prev_res_q) begin
            match_d = '0;
        end else if (match_q != MATCH_LAST) begin
            match_d = match_q + 1'b1;
        end
        stable_d = (match_d == MATCH_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q    <= '0;
            col_idx_q  <= '0;
            lows_q     <= '0;
            acc_code_q <= '0;
            prev_res_q <= NO_KEY;
            match_q    <= '0;
        end else if (sample_d) begin
            dwell_q   <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            if (scan_end_d) begin
                lows_q     <= '0;
                acc_code_q <= '0;
                prev_res_q <= res_d;
                match_q    <= match_d;
            end else begin
                lows_q     <= lows_d;
                acc_code_q <= acc_code_d;
            end
        end else begin
            dwell_q <= dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_end_d && stable_d) begin
                case (state_q)
                    S_IDLE: begin
                        if (res_d[KEY_W]) begin
                            key_code_q  <= res_d[KEY_W-1:0];
                            key_valid_q <= 1'b1;
                            key_down_q  <= 1'b1;
                            state_q     <= S_HELD;
                        end
                    end
                    S_HELD: begin
                        if (!res_d[KEY_W]) begin
                            key_down_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else if (res_d[KEY_W-1:0] != key_code_q) begin
                            key_code_q  <= res_d[KEY_W-1:0];
                            key_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: keypad matrix model, expected-code scoreboard, pulse monitor.
module tb_keypad_scanner;

    localparam int unsigned LAT = 67;

    logic        clk;
    logic        rst;
    logic [15:0] pressed;
    logic [3:0]  row_m;
    logic [3:0]  exp_col;
    logic [3:0]  exp_c;
    int unsigned total;
    int unsigned bad;
    int unsigned pulses;
    int unsigned p0;
    logic [3:0]  exp_q[$];

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_m = '1;
        for (int r = 0; r < 4; r++) begin
            row_m[r] = ~|(pressed[r*4 +: 4] & ~kif.col);
        end
    end
    assign kif.row = row_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            pulses++;
            check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_c = exp_q.pop_front();
                check("pulse_code", 32'(kif.key_code), 32'(exp_c));
            end
        end
    end

    task automatic wait_pulse(input string tag);
        int unsigned start;
        int unsigned n;
        start = pulses;
        n = 0;
        while (pulses == start && n < LAT) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(pulses - start), 32'd1);
    endtask

    task automatic wait_release(input string tag);
        int unsigned n;
        n = 0;
        while (kif.key_down !== 1'b0 && n < LAT) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(kif.key_down), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        pulses  = 0;
        pressed = '0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 1: reset values and column sequencing
        check("rst_key_code",  32'(kif.key_code),  32'd0);
        check("rst_key_valid", 32'(kif.key_valid), 32'd0);
        check("rst_key_down",  32'(kif.key_down),  32'd0);
        for (int unsigned k = 0; k < 200; k++) begin
            exp_col = 4'b1111;
            exp_col[(k / 4) % 4] = 1'b0;
            check("col_seq", 32'(kif.col), 32'(exp_col));
            @(negedge clk);
            #1;
        end
        check("idle_key_code", 32'(kif.key_code), 32'd0);
        check("idle_key_down", 32'(kif.key_down), 32'd0);
        check("idle_pulses",   32'(pulses),       32'd0);

        // 2: steady press (1,2), then hold without repeat
        exp_q.push_back(4'd6);
        pressed[6] = 1'b1;
        wait_pulse("press_6_latency");
        check("press_6_code", 32'(kif.key_code), 32'd6);
        check("press_6_down", 32'(kif.key_down), 32'd1);
        p0 = pulses;
        repeat (500) @(negedge clk);
        #1;
        check("hold_no_repeat", 32'(pulses - p0), 32'd0);

        // 3: release keeps code
        pressed = '0;
        wait_release("release_6_down");
        check("release_6_code", 32'(kif.key_code), 32'd6);
        check("release_no_pulse", 32'(pulses - p0), 32'd0);

        // 4: bouncing (0,0), then steady
        for (int unsigned i = 0; i < 20; i++) begin
            pressed[0] = ~pressed[0];
            repeat (5) @(negedge clk);
        end
        #1;
        check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        exp_q.push_back(4'd0);
        pressed[0] = 1'b1;
        wait_pulse("bounce_then_steady");
        check("press_0_code", 32'(kif.key_code), 32'd0);
        pressed = '0;
        wait_release("release_0_down");

        // 5: two keys ghost to nothing; release one; roll-over
        p0 = pulses;
        pressed[15] = 1'b1;
        pressed[9]  = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("multi_no_pulse", 32'(pulses - p0), 32'd0);
        check("multi_no_down",  32'(kif.key_down), 32'd0);
        exp_q.push_back(4'd15);
        pressed[9] = 1'b0;
        wait_pulse("single_15_latency");
        check("single_15_code", 32'(kif.key_code), 32'd15);
        exp_q.push_back(4'd1);
        pressed[15] = 1'b0;
        pressed[1]  = 1'b1;
        wait_pulse("rollover_1_latency");
        check("rollover_1_code", 32'(kif.key_code), 32'd1);
        check("rollover_1_down", 32'(kif.key_down), 32'd1);
        pressed = '0;
        wait_release("release_1_down");

        // 6: reset while (1,1) is held
        exp_q.push_back(4'd5);
        pressed[5] = 1'b1;
        wait_pulse("press_5_latency");
        check("press_5_down", 32'(kif.key_down), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_key_down",  32'(kif.key_down),  32'd0);
        check("midrst_key_code",  32'(kif.key_code),  32'd0);
        check("midrst_col",       32'(kif.col),       32'hE);
        check("midrst_key_valid", 32'(kif.key_valid), 32'd0);
        exp_q.push_back(4'd5);
        wait_pulse("reaccept_5_latency");
        check("reaccept_5_code", 32'(kif.key_code), 32'd5);
        pressed = '0;
        wait_release("release_5_down");

        repeat (20) @(negedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart of the four-digit seven-segment driver. The display block time-multiplexes active-low anodes to drive outputs; this block time-multiplexes active-low columns of a 4x4 matrix keypad to read rows. It produces a debounced 4-bit key code and a one-cycle key_valid strobe. The top level uses these to load SSD/LED selects, or to enter values instead of using slide switches.

Parameters:
SCAN_DIV, 2500, clk cycles each column is held active; must be >= 4.
DEBOUNCE_SCANS, 8, consecutive identical full scans needed to accept a press or a release; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
row  input  4  keypad rows, active-low (pulled up), asynchronous to clk
col  output  4  keypad column drive, active-low one-hot (1110 = column 0 ... 0111 = column 3)
key_code  output  4  code of last accepted key = row_idx*4 + col_idx
key_valid  output  1  one-cycle pulse when a new press is accepted
key_down  output  1  high while the accepted key is held (press accepted, release not yet accepted)

Behaviour:
- Reset values: col=1110, key_code=0, key_valid=0, key_down=0, FSM=S_IDLE, all counters 0, synchronizer flops 1111.
- row passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Column sequencing:
  - dwell counter runs 0..SCAN_DIV-1; col_idx advances 0->1->2->3->0 when dwell reaches SCAN_DIV-1.
  - col = ~(1<<col_idx).
  - One full scan = 4*SCAN_DIV cycles.
- Sampling: synchronized rows are sampled on the last dwell cycle (dwell==SCAN_DIV-1) of each column. This leaves SCAN_DIV-1 cycles for matrix settling plus synchronizer delay.
- Per-scan result, evaluated when the col_idx==3 sample is taken:
  - exactly one low row bit across the whole scan -> SINGLE(code).
  - zero low bits -> NONE.
  - two or more low bits (ghosting/multi-press) -> NONE.
- Scan comparison:
  - match counter increments when the result equals the previous scan result, saturating at DEBOUNCE_SCANS-1.
  - any change reloads the counter to 0 and stores the new result.
  - "stable" = counter reaches DEBOUNCE_SCANS-1, i.e. DEBOUNCE_SCANS identical scans in a row.
- FSM (evaluated only at scan end):
  - S_IDLE: stable SINGLE(c) -> key_code<=c, key_valid pulse, key_down<=1, go to S_HELD. Otherwise stay.
  - S_HELD:
    - stable NONE -> key_down<=0, go to S_IDLE.
    - stable SINGLE(c') with c' != key_code (roll-over) -> key_code<=c', key_valid pulse, stay.
    - stable SINGLE(key_code) -> no pulse (no auto-repeat).
  - The debounce counter lives outside the FSM; no separate confirm state.
- key_valid and key_code are registered.
  - key_valid is high for exactly the cycle after the final scan-end sample.
  - key_code changes in that same cycle and holds until the next accepted press. Release does not clear it.
- Press latency from a stable key: at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- Bounce within a scan window shorter than one full scan can delay acceptance but never produces two pulses.
- Reset mid-scan or while held: everything returns to reset values on the next edge, with no key_valid pulse. A key still held after reset is re-accepted as a fresh press after DEBOUNCE_SCANS scans.

Decomposition:
- Package keypad_pkg:
  - FSM state enum (S_IDLE, S_HELD).
  - NO_KEY result encoding: 5-bit result with bit4 = valid.
  - KEY_W=4, N_ROWS=4, N_COLS=4.
- Sub-module keypad_row_sync: 4-bit 2-flop synchronizer, reset to 1111. Reused for slide switches and buttons elsewhere.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan = 16 cycles). The matrix model pulls row[r] low whenever col[c]==0 and key (r,c) is pressed.
1. Reset, no keys, 200 cycles -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never high; key_code=0; key_down=0.
2. Press (row1,col2) steadily -> exactly one key_valid pulse within (3+1)*16+3=67 cycles, key_code=6, key_down=1. Hold 500 cycles -> no further pulse.
3. Release after test 2 -> key_down falls within 67 cycles; key_code stays 6; no pulse.
4. Press (0,0) toggling every 5 cycles for 100 cycles, then steady -> no pulse during bouncing; one pulse after steady, key_code=0.
5. Hold (3,3) and (2,1) together -> no pulse. Release (2,1) -> one pulse, key_code=15. Roll-over from (3,3) to (0,1) with no gap -> second pulse, key_code=1.
6. Assert rst for 1 cycle while (1,1) is held and key_down=1 -> next cycle key_down=0, key_code=0, col=1110. Pulse with key_code=5 reappears after debounce.
